// File: rtl/matmul_apb_master.sv
// APB requester for the matmul engine: turns single command requests into
// SETUP/ACCESS APB transfers and returns one response per command.
module matmul_apb_master #(
   parameter int DATA_WIDTH  = 8,
   parameter int BUS_WIDTH   = 32,
   parameter int ADDR_WIDTH  = 16,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   cmd_valid_i,
   output logic                   cmd_ready_o,
   input  logic                   cmd_write_i,
   input  logic [ADDR_WIDTH-1:0]  cmd_addr_i,
   input  logic [BUS_WIDTH-1:0]   cmd_wdata_i,
   input  logic [BUS_WIDTH/8-1:0] cmd_strb_i,
   output logic                   psel_o,
   output logic                   penable_o,
   output logic                   pwrite_o,
   output logic [ADDR_WIDTH-1:0]  paddr_o,
   output logic [BUS_WIDTH-1:0]   pwdata_o,
   output logic [BUS_WIDTH/8-1:0] pstrb_o,
   input  logic                   pready_i,
   input  logic                   pslverr_i,
   input  logic [BUS_WIDTH-1:0]   prdata_i,
   output logic                   rsp_valid_o,
   input  logic                   rsp_ready_i,
   output logic [BUS_WIDTH-1:0]   rsp_rdata_o,
   output logic                   rsp_slverr_o,
   output logic                   rsp_timeout_o,
   output logic                   busy_o
);

   localparam int STRB_W = BUS_WIDTH / 8;
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

   if (DATA_WIDTH < 1 || (BUS_WIDTH % 8) != 0 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_param_chk
      $error("matmul_apb_master: illegal parameter set");
   end

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

   state_e                state_q, state_d;
   logic [7:0]            cnt_q, cnt_d;
   logic                  write_q, write_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [BUS_WIDTH-1:0]  wdata_q, wdata_d;
   logic [STRB_W-1:0]     strb_q, strb_d;
   logic [BUS_WIDTH-1:0]  rdata_q, rdata_d;
   logic                  slverr_q, slverr_d;
   logic                  timeout_q, timeout_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         write_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         strb_q    <= '0;
         rdata_q   <= '0;
         slverr_q  <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         write_q   <= write_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         strb_q    <= strb_d;
         rdata_q   <= rdata_d;
         slverr_q  <= slverr_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      write_d   = write_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      strb_d    = strb_q;
      rdata_d   = rdata_q;
      slverr_d  = slverr_q;
      timeout_d = timeout_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid_i) begin
               state_d = SETUP;
               write_d = cmd_write_i;
               addr_d  = cmd_addr_i;
               // Reads put zeros on the write-data and strobe lanes.
               wdata_d = cmd_write_i ? cmd_wdata_i : '0;
               strb_d  = cmd_write_i ? cmd_strb_i  : '0;
            end
         end
         SETUP: begin
            state_d = ACCESS;
            cnt_d   = '0;
         end
         ACCESS: begin
            if (pready_i) begin
               state_d   = RESP;
               rdata_d   = write_q ? '0 : prdata_i;
               slverr_d  = pslverr_i;
               timeout_d = 1'b0;
            end else if (cnt_q == TO_LAST) begin
               state_d   = RESP;
               rdata_d   = '0;
               slverr_d  = 1'b1;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         RESP: begin
            if (rsp_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign cmd_ready_o   = (state_q == IDLE);
   assign busy_o        = (state_q != IDLE);
   assign psel_o        = (state_q == SETUP) || (state_q == ACCESS);
   assign penable_o     = (state_q == ACCESS);
   assign pwrite_o      = write_q;
   assign paddr_o       = addr_q;
   assign pwdata_o      = wdata_q;
   assign pstrb_o       = strb_q;
   assign rsp_valid_o   = (state_q == RESP);
   assign rsp_rdata_o   = rdata_q;
   assign rsp_slverr_o  = slverr_q;
   assign rsp_timeout_o = timeout_q;

endmodule

// File: tb/tb_matmul_apb_master.sv
// Directed bench for matmul_apb_master: a per-transaction cycle schedule model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_matmul_apb_master;
   localparam int TO = 16;

   logic        clk, rst_ni;
   logic        cmd_valid_i, cmd_ready_o, cmd_write_i;
   logic [15:0] cmd_addr_i;
   logic [31:0] cmd_wdata_i;
   logic [3:0]  cmd_strb_i;
   logic        psel_o, penable_o, pwrite_o;
   logic [15:0] paddr_o;
   logic [31:0] pwdata_o;
   logic [3:0]  pstrb_o;
   logic        pready_i, pslverr_i;
   logic [31:0] prdata_i;
   logic        rsp_valid_o, rsp_ready_i;
   logic [31:0] rsp_rdata_o;
   logic        rsp_slverr_o, rsp_timeout_o, busy_o;

   matmul_apb_master #(.DATA_WIDTH(8), .BUS_WIDTH(32), .ADDR_WIDTH(16), .TIMEOUT_CYC(TO)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
      .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_strb_i(cmd_strb_i),
      .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
      .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
      .pready_i(pready_i), .pslverr_i(pslverr_i), .prdata_i(prdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_rdata_o(rsp_rdata_o), .rsp_slverr_o(rsp_slverr_o),
      .rsp_timeout_o(rsp_timeout_o), .busy_o(busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0, n_fail = 0;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Transaction schedule model: SETUP cycle S, A ACCESS cycles, response
   // valid from S+A+1 up to and including the release cycle R.
   bit          chk_en = 0, active = 0;
   int          S, A, R;
   logic        e_wr, e_err, e_to;
   logic [15:0] e_addr;
   logic [31:0] e_wd, e_rd;
   logic [3:0]  e_st;

   always @(negedge clk) begin
      if (chk_en) begin
         int  k;
         bit  e_psel, e_pen, e_rv;
         k      = cyc;
         e_psel = active && k >= S && k <= S + A;
         e_pen  = active && k >= S + 1 && k <= S + A;
         e_rv   = active && k >= S + A + 1 && k <= R;
         chk("psel", psel_o, e_psel);
         chk("penable", penable_o, e_pen);
         chk("rsp_valid", rsp_valid_o, e_rv);
         chk("busy", busy_o, e_psel || e_rv);
         chk("cmd_ready", cmd_ready_o, !(e_psel || e_rv));
         if (e_psel) begin
            chk("pwrite", pwrite_o, e_wr);
            chk("paddr", paddr_o, e_addr);
            chk("pwdata", pwdata_o, e_wr ? e_wd : 32'h0);
            chk("pstrb", pstrb_o, e_wr ? e_st : 4'h0);
         end
         if (e_rv) begin
            chk("rsp_rdata", rsp_rdata_o, e_rd);
            chk("rsp_slverr", rsp_slverr_o, e_err);
            chk("rsp_timeout", rsp_timeout_o, e_to);
         end
      end
   end

   // Observations of the last transaction, offsets relative to the accept cycle.
   int          o_psel1, o_pen1, o_rv1, o_psel_n;
   logic [31:0] o_rdata;
   logic        o_slverr, o_to;
   logic [3:0]  o_strb_or;

   task automatic drive_apb(input int k, input int wait_n, input bit tie, input logic err,
                            input logic [31:0] rd);
      bit rdy;
      rdy       = tie || (wait_n < TO && k == S + 1 + wait_n);
      pready_i  = rdy;
      prdata_i  = rdy ? rd : (32'hDEAD_BEEF ^ 32'(k));
      pslverr_i = rdy ? err : 1'b1;
   endtask

   task automatic run_txn(input logic wr, input logic [15:0] addr, input logic [31:0] wd,
                          input logic [3:0] st, input int wait_n, input logic err,
                          input logic [31:0] rd, input int hold, input bit tie, input bit keep);
      int c, k;
      @(negedge clk);
      c = cyc;
      S = c + 1;
      A = (wait_n >= TO) ? TO : wait_n + 1;
      R = S + A + 1 + hold;
      e_wr = wr; e_addr = addr; e_wd = wd; e_st = st;
      e_to  = (wait_n >= TO);
      e_err = e_to ? 1'b1 : err;
      e_rd  = (e_to || wr) ? 32'h0 : rd;
      active = 1;
      cmd_valid_i = 1; cmd_write_i = wr; cmd_addr_i = addr; cmd_wdata_i = wd; cmd_strb_i = st;
      rsp_ready_i = 0;
      drive_apb(c, wait_n, tie, err, rd);
      o_psel1 = -1; o_pen1 = -1; o_rv1 = -1; o_psel_n = 0; o_strb_or = 0;
      o_rdata = 32'hFFFF_FFFF; o_slverr = 1'bx; o_to = 1'bx;
      do begin
         @(negedge clk);
         k = cyc;
         if (k == c + 1) begin
            // Command fields change after accept; the DUT must hold its copy.
            cmd_valid_i = keep; cmd_write_i = ~wr; cmd_addr_i = ~addr;
            cmd_wdata_i = ~wd; cmd_strb_i = ~st;
         end
         if (k > R) begin
            cmd_valid_i = 0; rsp_ready_i = 0; pready_i = 0; pslverr_i = 0; prdata_i = 0;
         end else begin
            drive_apb(k, wait_n, tie, err, rd);
            rsp_ready_i = (k >= S + A + 1 + hold);
            if (psel_o) begin
               o_psel_n++;
               o_strb_or |= pstrb_o;
               if (o_psel1 < 0) o_psel1 = k - c;
            end
            if (penable_o && o_pen1 < 0) o_pen1 = k - c;
            if (rsp_valid_o && o_rv1 < 0) begin
               o_rv1 = k - c; o_rdata = rsp_rdata_o; o_slverr = rsp_slverr_o; o_to = rsp_timeout_o;
            end
         end
      end while (k <= R);
   endtask

   initial begin
      rst_ni = 1; cmd_valid_i = 0; cmd_write_i = 0; cmd_addr_i = 0; cmd_wdata_i = 0;
      cmd_strb_i = 0; pready_i = 0; pslverr_i = 0; prdata_i = 0; rsp_ready_i = 0;
      #1 rst_ni = 0;
      #2;
      chk("reset_psel", psel_o, 0);
      chk("reset_rsp_valid", rsp_valid_o, 0);
      chk("reset_busy", busy_o, 0);
      chk("reset_paddr", paddr_o, 0);
      repeat (2) @(negedge clk);
      rst_ni = 1;
      @(posedge clk); #1;
      chk("post_reset_cmd_ready", cmd_ready_o, 1);
      chk_en = 1;

      // Write, completer ready tied high.
      run_txn(1, 16'h0010, 32'h0000_00A5, 4'hF, 0, 0, 32'h5555_AAAA, 0, 1, 0);
      chk("wr_psel_offset", o_psel1, 1);
      chk("wr_penable_offset", o_pen1, 2);
      chk("wr_rsp_offset", o_rv1, 3);
      chk("wr_slverr", o_slverr, 0);
      chk("wr_rdata_zero", o_rdata, 32'h0);

      // Read with 3 wait states.
      run_txn(0, 16'h0020, 32'hFFFF_FFFF, 4'hF, 3, 0, 32'h1234_5678, 0, 0, 0);
      chk("rd_rdata", o_rdata, 32'h1234_5678);
      chk("rd_psel_cycles", o_psel_n, 5);
      chk("rd_pstrb_zero", o_strb_or, 0);
      chk("rd_rsp_offset", o_rv1, 6);

      // Read completed with an error.
      run_txn(0, 16'h0030, 32'h0, 4'h0, 0, 1, 32'h0000_0077, 0, 0, 0);
      chk("err_slverr", o_slverr, 1);
      chk("err_timeout", o_to, 0);

      // Completer never ready: timeout.
      run_txn(0, 16'h0040, 32'h0, 4'h0, 40, 0, 32'h0, 0, 0, 0);
      chk("to_psel_cycles", o_psel_n, 17);
      chk("to_slverr", o_slverr, 1);
      chk("to_timeout", o_to, 1);
      chk("to_rdata", o_rdata, 32'h0);

      // Response held for 4 cycles while another command is requested.
      run_txn(1, 16'h0050, 32'hCAFE_F00D, 4'h5, 0, 0, 32'h0, 4, 0, 1);
      chk("hold_psel_cycles", o_psel_n, 2);

      // Write with wait state and error; read data must not leak into response.
      run_txn(1, 16'h0060, 32'h0BAD_F00D, 4'h3, 1, 1, 32'h9999_9999, 1, 0, 0);
      chk("wr_err_slverr", o_slverr, 1);
      chk("wr_err_rdata", o_rdata, 32'h0);

      // Asynchronous reset mid-ACCESS.
      chk_en = 0;
      @(negedge clk);
      cmd_valid_i = 1; cmd_write_i = 1; cmd_addr_i = 16'h0044;
      cmd_wdata_i = 32'h1122_3344; cmd_strb_i = 4'hF; pready_i = 0;
      @(negedge clk);
      cmd_valid_i = 0;
      @(negedge clk);
      chk("pre_rst_penable", penable_o, 1);
      chk("pre_rst_pwrite", pwrite_o, 1);
      #2 rst_ni = 0;
      #1;
      chk("rst_psel", psel_o, 0);
      chk("rst_penable", penable_o, 0);
      chk("rst_pwrite", pwrite_o, 0);
      chk("rst_paddr", paddr_o, 0);
      chk("rst_pwdata", pwdata_o, 0);
      chk("rst_pstrb", pstrb_o, 0);
      chk("rst_rsp_valid", rsp_valid_o, 0);
      chk("rst_busy", busy_o, 0);
      @(negedge clk);
      rst_ni = 1;
      @(posedge clk); #1;
      chk("rst_cmd_ready", cmd_ready_o, 1);
      repeat (6) begin
         @(negedge clk);
         chk("rst_no_rsp", rsp_valid_o, 0);
         chk("rst_no_psel", psel_o, 0);
      end
      active = 0;
      chk_en = 1;

      // Normal operation after the aborted transfer.
      run_txn(0, 16'h0070, 32'h0, 4'h0, 2, 0, 32'h0BAD_C0DE, 0, 0, 0);
      chk("post_rst_rdata", o_rdata, 32'h0BAD_C0DE);
      chk("post_rst_psel_cycles", o_psel_n, 4);

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/matmul_apb_master.md
MATMUL_APB_MASTER -- requirements
Module: matmul_apb_master

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of one matrix element; carried for package consistency, no internal use.
REQ-002 Parameter BUS_WIDTH, default 32, APB data-bus width in bits; multiple of 8.
REQ-003 Parameter ADDR_WIDTH, default 16, APB address width.
REQ-004 Parameter TIMEOUT_CYC, default 16, maximum ACCESS-phase cycles before forced termination; range 1..255.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-006 clk_i  in  1  rising-edge clock.
REQ-007 rst_ni  in  1  asynchronous reset, active low.
REQ-008 cmd_valid_i  in  1  command request.
REQ-009 cmd_ready_o  out  1  command accepted when both valid and ready are high at a rising edge.
REQ-010 cmd_write_i  in  1  1 = write, 0 = read.
REQ-011 cmd_addr_i  in  ADDR_WIDTH  target address.
REQ-012 cmd_wdata_i  in  BUS_WIDTH  write data.
REQ-013 cmd_strb_i  in  BUS_WIDTH/8  write byte strobes.
REQ-014 psel_o, penable_o, pwrite_o  out  1 each  APB control.
REQ-015 paddr_o  out  ADDR_WIDTH; pwdata_o  out  BUS_WIDTH; pstrb_o  out  BUS_WIDTH/8  APB request fields.
REQ-016 pready_i, pslverr_i  in  1 each; prdata_i  in  BUS_WIDTH  APB completer response.
REQ-017 rsp_valid_o  out  1; rsp_ready_i  in  1  response handshake.
REQ-018 rsp_rdata_o  out  BUS_WIDTH; rsp_slverr_o  out  1; rsp_timeout_o  out  1  response payload.
REQ-019 busy_o  out  1  high in every state except IDLE.

Function
REQ-020 The FSM SHALL have states IDLE, SETUP, ACCESS and RESP.
REQ-021 cmd_ready_o SHALL be 1 only in IDLE.
- IDLE -> SETUP on accept.
- Command fields are registered at accept.
REQ-022 SETUP SHALL last exactly one cycle, with psel_o=1 and penable_o=0, then go to ACCESS.
REQ-023 ACCESS SHALL drive psel_o=1 and penable_o=1 until pready_i=1 is sampled.
REQ-024 paddr_o, pwrite_o, pwdata_o and pstrb_o SHALL be stable from SETUP through the completing ACCESS cycle.
REQ-025 Read commands SHALL drive pstrb_o=0 and pwdata_o=0.
REQ-026 On a sampled pready_i=1, the block SHALL capture prdata_i and pslverr_i, go to RESP, and deassert psel_o and penable_o in the next cycle.
REQ-027 For writes, the captured rsp_rdata_o SHALL be 0.
REQ-028 pslverr_i and prdata_i SHALL be ignored unless sampled together with pready_i=1 in ACCESS.
REQ-029 A counter SHALL count ACCESS cycles.
- Timeout: counter reaches TIMEOUT_CYC with pready_i=0.
- On timeout: go to RESP with rsp_slverr_o=1, rsp_timeout_o=1, rsp_rdata_o=0.
REQ-030 RESP SHALL hold rsp_valid_o=1 and a stable payload until rsp_ready_i=1, then go to IDLE.
- The next command cannot be accepted in the same cycle.
REQ-031 Minimum latency, zero-wait completer: accept edge N -> SETUP cycle N+1 -> ACCESS cycle N+2 -> rsp_valid_o=1 in cycle N+3.
REQ-032 The block SHALL have only one outstanding transfer; cmd_valid_i outside IDLE SHALL have no effect.

Reset
REQ-033 When rst_ni=0, the block SHALL immediately, without waiting for a clock edge:
- set the FSM to IDLE;
- set all outputs to 0 except cmd_ready_o;
- clear the counter and captured registers.
REQ-034 cmd_ready_o SHALL be 1 from the first rising edge after rst_ni returns to 1.
REQ-035 A reset during SETUP, ACCESS or RESP SHALL abort the transfer with no response.

Verification
REQ-036 Write 0x0000_00A5 to 0x0010, strb 0xF, pready_i tied 1 -> psel_o in N+1, penable_o in N+2, rsp_valid_o in N+3, rsp_slverr_o=0.
REQ-037 Read 0x0020, completer gives 3 wait states then prdata_i=0x1234_5678 -> rsp_rdata_o=0x1234_5678, 5 cycles of psel_o, pstrb_o=0.
REQ-038 Read with pready_i=1 and pslverr_i=1 -> rsp_slverr_o=1, rsp_timeout_o=0.
REQ-039 pready_i held 0 -> after 16 ACCESS cycles, psel_o drops, rsp_slverr_o=1, rsp_timeout_o=1, rsp_rdata_o=0.
REQ-040 rsp_ready_i held 0 for 4 cycles with cmd_valid_i=1 -> rsp payload stable, cmd_ready_o=0, no new SETUP until release.
REQ-041 rst_ni pulsed low mid-ACCESS -> all outputs except cmd_ready_o go 0 asynchronously, FSM returns to IDLE, no response issued.
